multi_input_eval: RTL and testbench
===================================

Name: multi_input_eval

Overview:
- Parametrised, registered successor to the team's 3-input combinational evaluator.
- Evaluates a WIDTH-bit input vector under a runtime-selectable Boolean mode (AND/OR/XOR/MAJORITY).
- Output sits behind a 1-entry valid/ready buffer, with a saturating true-result counter and a run-length "streak" flag.
- Used as a reusable decision stage between datapath blocks and control logic.

Parameters:
- WIDTH, 3, number of input bits evaluated (>=1).
- CNT_W, 8, width of saturating true-result counter.
- STREAK, 4, consecutive true results required to raise streak (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_data  input  WIDTH  operand vector.
- in_mode  input  2  0=AND, 1=OR, 2=XOR, 3=MAJORITY; sampled with in_data.
- in_valid  input  1  in_data/in_mode valid.
- in_ready  output  1  block can accept input this cycle.
- out_ans  output  1  registered result.
- out_valid  output  1  out_ans valid.
- out_ready  input  1  consumer accepts out_ans.
- true_cnt  output  CNT_W  count of accepted results equal to 1, saturating at all-ones.
- streak  output  1  high while the last STREAK delivered results were all 1.
- clr_cnt  input  1  synchronous clear of true_cnt and streak history.

Behaviour:
- Reset is asynchronous and active-low. On rst_n=0: out_ans=0, out_valid=0, true_cnt=0, streak=0, history=0. in_ready=1 once rst_n=1.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Combinational ready: in_ready = !out_valid || out_ready. Full-throughput back-to-back operation is allowed.
- Latency: 1 cycle. The result of a transfer at edge k appears on out_ans/out_valid after edge k.
- out_valid, set:
  - Set on an input transfer.
  - Set when an input transfer and an output transfer happen in the same cycle (new data replaces old).
- out_valid, clear: cleared on an output transfer with no input transfer.
- Stall: while out_valid && !out_ready, out_ans is held stable and in_ready=0. Input is not lost because the producer must hold in_valid.
- Modes:
  - AND: &in_data.
  - OR: |in_data.
  - XOR: ^in_data.
  - MAJORITY: 1 iff 2*popcount(in_data) > WIDTH. Ties at even WIDTH give 0.
  - Internal popcount width is clog2(WIDTH+1).
- true_cnt: increments on each output transfer whose out_ans=1. Holds at 2^CNT_W-1 with no wrap.
- history: a STREAK-bit shift register.
  - On each output transfer it shifts in out_ans.
  - streak = &history, registered, and updates the cycle after the transfer.
- clr_cnt=1 at an edge: true_cnt<=0, history<=0, streak<=0. It has priority over a same-cycle increment or shift; that output transfer is still completed but not counted.
- clr_cnt does not affect out_ans/out_valid.
- Reset mid-stall: the pending result is discarded and out_valid drops immediately.
- in_mode outside the transfer cycle is ignored.

Optional Feature:
- Macro EVAL_POPCOUNT_EN.
- Defined:
  - Adds port out_pop (output, clog2(WIDTH+1)), the registered popcount of the accepted in_data.
  - out_pop follows the same valid/hold rules as out_ans and resets to 0.
- Undefined:
  - The port is absent.
  - The popcount logic exists only as needed for MAJORITY mode.

Test Plan:
- WIDTH=3, out_ready=1; in_data=3'b011 in each mode 0..3 -> out_ans 0,1,0,1, each one cycle after its transfer.
- WIDTH=4, MAJORITY, in_data=4'b0011 -> out_ans=0 (tie); 4'b0111 -> out_ans=1.
- out_ready=0 after one transfer of 3'b111 AND -> out_valid=1, out_ans=1 held, in_ready=0 for 5 cycles; out_ready=1 with new in_valid -> same-cycle swap, no bubble.
- CNT_W=2, four accepted 1-results -> true_cnt 1,2,3,3 (saturates); clr_cnt pulse -> true_cnt=0 next cycle.
- STREAK=4, delivered results 1,1,1,0,1,1,1,1 -> streak high only after the 8th transfer; rst_n low mid-stream -> all outputs 0 asynchronously.
- EVAL_POPCOUNT_EN defined, WIDTH=5, in_data=5'b10110 -> out_pop=3 aligned with out_valid.

Source files
------------

// File: rtl/multi_input_eval.sv
// Registered multi-input Boolean evaluator (AND/OR/XOR/MAJORITY) behind a 1-entry valid/ready
// buffer, with a saturating true-result counter and streak flag. Optional EVAL_POPCOUNT_EN adds out_pop.
module multi_input_eval #(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned STREAK = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [1:0]                 in_mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       out_ans,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CNT_W-1:0]           true_cnt,
  output logic                       streak,
  input  logic                       clr_cnt
`ifdef EVAL_POPCOUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] out_pop
`endif
);

  localparam int unsigned POP_W = $clog2(WIDTH + 1);

  localparam logic [1:0] MODE_AND = 2'd0;
  localparam logic [1:0] MODE_OR  = 2'd1;
  localparam logic [1:0] MODE_XOR = 2'd2;
  localparam logic [1:0] MODE_MAJ = 2'd3;

  // WIDTH widened by one bit so 2*popcount can be compared without overflow
  localparam logic [POP_W:0] WIDTH_CMP = (POP_W + 1)'(WIDTH);

  logic             out_ans_q,   out_ans_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] true_cnt_q,  true_cnt_d;
  logic [STREAK-1:0] history_q,  history_d;
  logic             streak_q,    streak_d;

  logic             in_xfer;
  logic             out_xfer;
  logic [POP_W-1:0] pop_c;
  logic             ans_c;

  // Population count of the operand vector
  always_comb begin
    pop_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      pop_c = pop_c + POP_W'(in_data[i]);
    end
  end

  // Mode-selected evaluation of the operand vector
  always_comb begin
    ans_c = 1'b0;
    case (in_mode)
      MODE_AND: ans_c = &in_data;
      MODE_OR:  ans_c = |in_data;
      MODE_XOR: ans_c = ^in_data;
      MODE_MAJ: ans_c = ({pop_c, 1'b0} > WIDTH_CMP);
      default:  ans_c = 1'b0;
    endcase
  end

  assign in_ready = !out_valid_q || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  // Output buffer, counter and history next-state
  always_comb begin
    out_ans_d   = out_ans_q;
    out_valid_d = out_valid_q;
    true_cnt_d  = true_cnt_q;
    history_d   = history_q;

    if (in_xfer) begin
      out_ans_d   = ans_c;
      out_valid_d = 1'b1;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end

    // A clear wins over the count/shift of a same-cycle delivery
    if (clr_cnt) begin
      true_cnt_d = '0;
      history_d  = '0;
    end else if (out_xfer) begin
      history_d = (history_q << 1) | STREAK'(out_ans_q);
      if (out_ans_q && (true_cnt_q != {CNT_W{1'b1}})) begin
        true_cnt_d = true_cnt_q + CNT_W'(1);
      end
    end

    streak_d = &history_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ans_q   <= 1'b0;
      out_valid_q <= 1'b0;
      true_cnt_q  <= '0;
      history_q   <= '0;
      streak_q    <= 1'b0;
    end else begin
      out_ans_q   <= out_ans_d;
      out_valid_q <= out_valid_d;
      true_cnt_q  <= true_cnt_d;
      history_q   <= history_d;
      streak_q    <= streak_d;
    end
  end

  assign out_ans   = out_ans_q;
  assign out_valid = out_valid_q;
  assign true_cnt  = true_cnt_q;
  assign streak    = streak_q;

`ifdef EVAL_POPCOUNT_EN
  logic [POP_W-1:0] out_pop_q, out_pop_d;

  // Popcount is captured and held under the same rules as out_ans
  always_comb begin
    out_pop_d = out_pop_q;
    if (in_xfer) begin
      out_pop_d = pop_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pop_q <= '0;
    end else begin
      out_pop_q <= out_pop_d;
    end
  end

  assign out_pop = out_pop_q;
`endif

endmodule

// File: tb/tb_multi_input_eval.sv
// Directed self-checking bench for multi_input_eval: three instances (WIDTH 3/4/5) share clk/rst_n.
module tb_multi_input_eval;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: WIDTH=3, CNT_W=2, STREAK=4
  logic [2:0] a_data;
  logic [1:0] a_mode;
  logic       a_valid, a_ready, a_ans, a_ovalid, a_oready, a_streak, a_clr;
  logic [1:0] a_cnt;
  // Instance B: WIDTH=4
  logic [3:0] b_data;
  logic [1:0] b_mode;
  logic       b_valid, b_ready, b_ans, b_ovalid, b_oready, b_streak, b_clr;
  logic [7:0] b_cnt;
  // Instance C: WIDTH=5
  logic [4:0] c_data;
  logic [1:0] c_mode;
  logic       c_valid, c_ready, c_ans, c_ovalid, c_oready, c_streak, c_clr;
  logic [7:0] c_cnt;
`ifdef EVAL_POPCOUNT_EN
  logic [1:0] a_pop;
  logic [2:0] b_pop;
  logic [2:0] c_pop;
`endif

  multi_input_eval #(.WIDTH(3), .CNT_W(2), .STREAK(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_mode(a_mode), .in_valid(a_valid),
    .in_ready(a_ready), .out_ans(a_ans), .out_valid(a_ovalid), .out_ready(a_oready),
    .true_cnt(a_cnt), .streak(a_streak), .clr_cnt(a_clr)
`ifdef EVAL_POPCOUNT_EN
    , .out_pop(a_pop)
`endif
  );

  multi_input_eval #(.WIDTH(4), .CNT_W(8), .STREAK(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_mode(b_mode), .in_valid(b_valid),
    .in_ready(b_ready), .out_ans(b_ans), .out_valid(b_ovalid), .out_ready(b_oready),
    .true_cnt(b_cnt), .streak(b_streak), .clr_cnt(b_clr)
`ifdef EVAL_POPCOUNT_EN
    , .out_pop(b_pop)
`endif
  );

  multi_input_eval #(.WIDTH(5), .CNT_W(8), .STREAK(4)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_mode(c_mode), .in_valid(c_valid),
    .in_ready(c_ready), .out_ans(c_ans), .out_valid(c_ovalid), .out_ready(c_oready),
    .true_cnt(c_cnt), .streak(c_streak), .clr_cnt(c_clr)
`ifdef EVAL_POPCOUNT_EN
    , .out_pop(c_pop)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_clear();
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("clr_cnt", 32'(a_cnt), 32'd0);
    chk("clr_streak", 32'(a_streak), 32'd0);
  endtask

  logic [3:0] a_mode_exp  = 4'b1010;
  logic [7:0] a_streak_pat = 8'b1111_0111;
  logic [3:0] b_tab [4] = '{4'b0011, 4'b0111, 4'b1111, 4'b1000};
  logic [3:0] b_exp = 4'b0110;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    a_data = '0; a_mode = '0; a_valid = 1'b0; a_oready = 1'b1; a_clr = 1'b0;
    b_data = '0; b_mode = '0; b_valid = 1'b0; b_oready = 1'b1; b_clr = 1'b0;
    c_data = '0; c_mode = '0; c_valid = 1'b0; c_oready = 1'b1; c_clr = 1'b0;

    #12;
    chk("rst_ans", 32'(a_ans), 32'd0);
    chk("rst_valid", 32'(a_ovalid), 32'd0);
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    chk("rst_streak", 32'(a_streak), 32'd0);
    #10;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(a_ready), 32'd1);

    // Every mode on 3'b011: AND 0, OR 1, XOR 0, MAJ 1
    a_data = 3'b011;
    for (int m = 0; m < 4; m++) begin
      a_mode  = 2'(m);
      a_valid = 1'b1;
      tick();
      chk($sformatf("mode%0d_valid", m), 32'(a_ovalid), 32'd1);
      chk($sformatf("mode%0d_ans", m), 32'(a_ans), 32'(a_mode_exp[m]));
    end
    a_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(a_ovalid), 32'd0);
    chk("mode_cnt", 32'(a_cnt), 32'd2);
    a_clear();

    // Stall: result held, in_ready low, then same-cycle swap
    a_oready = 1'b0;
    a_data = 3'b111; a_mode = 2'd0; a_valid = 1'b1;
    tick();
    a_data = 3'b000;
    chk("stall0_valid", 32'(a_ovalid), 32'd1);
    chk("stall0_ans", 32'(a_ans), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("stall%0d_valid", i), 32'(a_ovalid), 32'd1);
      chk($sformatf("stall%0d_ans", i), 32'(a_ans), 32'd1);
      chk($sformatf("stall%0d_in_ready", i), 32'(a_ready), 32'd0);
    end
    a_oready = 1'b1;
    #1;
    chk("unstall_in_ready", 32'(a_ready), 32'd1);
    tick();
    chk("swap_valid", 32'(a_ovalid), 32'd1);
    chk("swap_ans", 32'(a_ans), 32'd0);
    chk("swap_cnt", 32'(a_cnt), 32'd1);
    a_valid = 1'b0;
    tick();
    chk("swap_drain_valid", 32'(a_ovalid), 32'd0);
    chk("swap_drain_cnt", 32'(a_cnt), 32'd1);
    a_clear();

    // Saturation at CNT_W=2: 1,2,3,3
    a_data = 3'b111; a_mode = 2'd0; a_valid = 1'b1;
    tick();
    chk("sat_first_cnt", 32'(a_cnt), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) a_valid = 1'b0;
      tick();
      chk($sformatf("sat%0d_cnt", i), 32'(a_cnt), 32'(i > 3 ? 3 : i));
    end
    chk("sat_streak", 32'(a_streak), 32'd1);
    a_clear();

    // Streak: deliveries 1,1,1,0,1,1,1,1 raise streak only after the 8th
    a_mode = 2'd0;
    for (int i = 0; i < 8; i++) begin
      a_data  = a_streak_pat[i] ? 3'b111 : 3'b000;
      a_valid = 1'b1;
      tick();
      chk($sformatf("streak_low%0d", i), 32'(a_streak), 32'd0);
    end
    a_valid = 1'b0;
    tick();
    chk("streak_high", 32'(a_streak), 32'd1);
    chk("streak_cnt", 32'(a_cnt), 32'd3);

    // Asynchronous reset during a stall
    a_oready = 1'b0;
    a_data = 3'b111; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    chk("prerst_valid", 32'(a_ovalid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(a_ovalid), 32'd0);
    chk("arst_ans", 32'(a_ans), 32'd0);
    chk("arst_cnt", 32'(a_cnt), 32'd0);
    chk("arst_streak", 32'(a_streak), 32'd0);
    #3;
    rst_n = 1'b1;
    #1;
    chk("arst_in_ready", 32'(a_ready), 32'd1);

    // WIDTH=4 majority: tie gives 0
    b_mode = 2'd3;
    for (int i = 0; i < 4; i++) begin
      b_data  = b_tab[i];
      b_valid = 1'b1;
      tick();
      chk($sformatf("maj4_%0d_valid", i), 32'(b_ovalid), 32'd1);
      chk($sformatf("maj4_%0d_ans", i), 32'(b_ans), 32'(b_exp[i]));
    end
    b_valid = 1'b0;

    // WIDTH=5 evaluation and popcount
    c_valid = 1'b1;
    c_mode = 2'd3; c_data = 5'b10110;
    tick();
    chk("w5_maj_valid", 32'(c_ovalid), 32'd1);
    chk("w5_maj_ans", 32'(c_ans), 32'd1);
`ifdef EVAL_POPCOUNT_EN
    chk("w5_pop_10110", 32'(c_pop), 32'd3);
`endif
    c_mode = 2'd2; c_data = 5'b10110;
    tick();
    chk("w5_xor_ans", 32'(c_ans), 32'd1);
    c_mode = 2'd0; c_data = 5'b11111;
    tick();
    chk("w5_and_ans", 32'(c_ans), 32'd1);
`ifdef EVAL_POPCOUNT_EN
    chk("w5_pop_11111", 32'(c_pop), 32'd5);
`endif
    c_mode = 2'd1; c_data = 5'b00000;
    tick();
    chk("w5_or_ans", 32'(c_ans), 32'd0);
`ifdef EVAL_POPCOUNT_EN
    chk("w5_pop_00000", 32'(c_pop), 32'd0);
`endif
    c_valid = 1'b0;
    tick();
    chk("w5_drain_valid", 32'(c_ovalid), 32'd0);
    chk("w5_cnt", 32'(c_cnt), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
